// File: rtl/ro_freq_counter.sv
// ro_freq_counter
//   Measures the frequency of a free-running ring oscillator. The block enables
//   the oscillator and lets it settle. It then counts rising edges of the
//   synchronized oscillator output over a fixed window of clk cycles. The result
//   is presented on a valid/ready handshake.
//
// Ports
//   clk          system clock, all state on its rising edge
//   rst          asynchronous, active-high reset
//   start        measurement request, sampled only in IDLE
//   ro_out       oscillator output, asynchronous to clk
//   ro_enable    oscillator enable, high in SETTLE and MEASURE
//   busy         high in any state other than IDLE
//   count_valid  result available
//   count_ready  consumer accepts result
//   count_out    rising-edge count of the last window (saturating)
//   overflow     counter saturated during the last window

module ro_freq_counter #(
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 ro_out,
    output logic                 ro_enable,
    output logic                 busy,
    output logic                 count_valid,
    input  logic                 count_ready,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic                 overflow
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]        SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]        GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0]        TIM_ONE     = TW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   count_out_q, count_out_d;
    logic                   overflow_q, overflow_d;
    logic                   count_valid_q, count_valid_d;

    logic s;
    logic rise;

    // Synchronized oscillator level and its one-cycle-delayed copy.
    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;

    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[SYNC_STAGES-2:0], ro_out};
        prev_d        = s;
        timer_d       = timer_q;
        cnt_d         = cnt_q;
        count_out_d   = count_out_q;
        overflow_d    = overflow_q;
        count_valid_d = count_valid_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    cnt_d      = '0;
                    overflow_d = 1'b0;
                    timer_d    = '0;
                end
            end

            SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    state_d = MEASURE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIM_ONE;
                end
            end

            MEASURE: begin
                // Saturate instead of wrapping. The flag records an edge that
                // arrived while the counter was already all-ones.
                if (rise) begin
                    if (cnt_q == '1) overflow_d = 1'b1;
                    else             cnt_d      = cnt_q + CNT_ONE;
                end
                if (timer_q == GATE_LAST) begin
                    // The edge seen in the final window cycle is included.
                    state_d       = DONE;
                    timer_d       = '0;
                    count_out_d   = cnt_d;
                    count_valid_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIM_ONE;
                end
            end

            DONE: begin
                if (count_ready) begin
                    state_d       = IDLE;
                    count_valid_d = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sync_q        <= '0;
            prev_q        <= 1'b0;
            timer_q       <= '0;
            cnt_q         <= '0;
            count_out_q   <= '0;
            overflow_q    <= 1'b0;
            count_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            prev_q        <= prev_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            count_out_q   <= count_out_d;
            overflow_q    <= overflow_d;
            count_valid_q <= count_valid_d;
        end
    end

    // Decoded straight from the state register so that reset drops them at once.
    assign ro_enable   = (state_q == SETTLE) || (state_q == MEASURE);
    assign busy        = (state_q != IDLE);
    assign count_valid = count_valid_q;
    assign count_out   = count_out_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
module tb_ro_freq_counter;

    localparam int GATE   = 100;
    localparam int SETTLE = 8;
    localparam int SYNC   = 2;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ro_out;
    logic          count_ready;
    logic          ro_enable;
    logic          busy;
    logic          count_valid;
    logic [CW-1:0] count_out;
    logic          overflow;

    ro_freq_counter #(
        .GATE_CYCLES  (GATE),
        .SETTLE_CYCLES(SETTLE),
        .SYNC_STAGES  (SYNC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ro_out     (ro_out),
        .ro_enable  (ro_enable),
        .busy       (busy),
        .count_valid(count_valid),
        .count_ready(count_ready),
        .count_out  (count_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // rh[n] is the ro_out level sampled by posedge number n.
    bit rh [0:65535];
    int cyc    = 0;
    int checks = 0;
    int passed = 0;

    // Oscillator model: 0 tied low, 1 tied high, 2 square wave (period per, high hi).
    int mode = 0;
    int per  = 10;
    int hi   = 5;
    int ph   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        ph++;
        case (mode)
            0:       ro_out = 1'b0;
            1:       ro_out = 1'b1;
            default: ro_out = ((ph % per) < hi);
        endcase
        rh[cyc + 1] = ro_out;
    endtask

    // Edges counted for a start sampled at edge t. The sampled level reaches the
    // edge detector SYNC edges later. The window is the GATE edges after SETTLE.
    function automatic int model_edges(input int t);
        int e;
        e = 0;
        for (int n = t + SETTLE + 1; n <= t + SETTLE + GATE; n++)
            if (rh[n - SYNC] && !rh[n - SYNC - 1]) e++;
        return e;
    endfunction

    task automatic wait_valid(output int n, output int en);
        n  = 1;
        en = 0;
        while (!count_valid && n < 400) begin
            if (ro_enable) en++;
            tick();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int t);
        int e;
        e = model_edges(t);
        chk({tag, " count_out"}, count_out, (e > CMAX) ? CMAX : e);
        chk({tag, " overflow"}, overflow, (e > CMAX) ? 1 : 0);
    endtask

    // One full measurement. The consumer stalls rdly cycles and optionally
    // toggles start while busy.
    task automatic run(input string tag, input int rdly, input bit poke);
        int t, n, en;
        logic [CW-1:0] held;
        start = 1'b1;
        t     = cyc + 1;
        tick();
        start = 1'b0;
        wait_valid(n, en);
        chk({tag, " latency"}, n, 1 + SETTLE + GATE);
        chk({tag, " enable_cycles"}, en, SETTLE + GATE);
        chk({tag, " enable_off_done"}, ro_enable, 0);
        check_result(tag, t);
        held = count_out;
        for (int i = 0; i < rdly; i++) begin
            if (poke) start = i[0];
            tick();
            chk({tag, " hold_valid"}, count_valid, 1);
            chk({tag, " hold_count"}, count_out, held);
        end
        start       = 1'b0;
        count_ready = 1'b1;
        tick();
        count_ready = 1'b0;
        chk({tag, " ack_valid"}, count_valid, 0);
        chk({tag, " ack_busy"}, busy, 0);
        tick();
        chk({tag, " no_requeue"}, busy, 0);
    endtask

    initial begin
        int t, n, en;
        rst         = 1'b1;
        start       = 1'b0;
        ro_out      = 1'b0;
        count_ready = 1'b0;
        tick();
        tick();
        chk("rst ro_enable", ro_enable, 0);
        chk("rst busy", busy, 0);
        chk("rst count_valid", count_valid, 0);
        chk("rst count_out", count_out, 0);
        chk("rst overflow", overflow, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Basic measurement at period 10.
        mode = 2; per = 10; hi = 5;
        run("basic", 0, 1'b0);

        // Stalled consumer, start pulses while busy.
        run("hold", 20, 1'b1);

        // Saturation: period 4 gives 25 edges in the window.
        per = 4; hi = 2;
        run("sat", 2, 1'b0);
        per = 10; hi = 5;
        run("post_sat", 0, 1'b0);

        // Reset 50 cycles into MEASURE.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < SETTLE + 50; i++) tick();
        chk("pre_rst busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst ro_enable", ro_enable, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst count_valid", count_valid, 0);
        chk("mid_rst count_out", count_out, 0);
        chk("mid_rst overflow", overflow, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst idle", busy, 0);
        run("after_rst", 1, 1'b0);

        // Idle oscillator.
        mode = 0;
        for (int i = 0; i < 4; i++) tick();
        run("tied0", 0, 1'b0);
        mode = 1;
        for (int i = 0; i < 4; i++) tick();
        run("tied1", 0, 1'b0);

        // Back-to-back with start and ready held high.
        mode = 2; per = 10; hi = 5;
        for (int i = 0; i < 4; i++) tick();
        start       = 1'b1;
        count_ready = 1'b1;
        t = cyc + 1;
        tick();
        wait_valid(n, en);
        chk("b2b1 latency", n, 1 + SETTLE + GATE);
        check_result("b2b1", t);
        tick();
        chk("b2b idle_valid", count_valid, 0);
        chk("b2b idle_busy", busy, 0);
        t = cyc + 1;
        tick();
        chk("b2b restart_busy", busy, 1);
        chk("b2b restart_enable", ro_enable, 1);
        wait_valid(n, en);
        chk("b2b2 latency", n, 1 + SETTLE + GATE);
        check_result("b2b2", t);
        start = 1'b0;
        tick();
        count_ready = 1'b0;
        chk("b2b final_busy", busy, 0);

        // Randomized square waves, including ones that saturate the counter.
        for (int r = 0; r < 6; r++) begin
            mode = 2;
            per  = $urandom_range(4, 30);
            hi   = $urandom_range(1, per - 1);
            ph   = $urandom_range(0, per - 1);
            for (int i = 0; i < 3; i++) tick();
            run($sformatf("rand%0d_p%0d", r, per), $urandom_range(0, 4), 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
Measures the frequency of the free-running ring-oscillator macro by counting its rising edges over a fixed window of system-clock cycles. It drives the oscillator's enable and consumes its output through a synchronizer. The block sits directly downstream of the oscillator and hands a count word to sensor/PUF logic using a valid/ready handshake.

Parameters:
GATE_CYCLES, 1024, length of the measurement window in clk cycles (≥2)
SETTLE_CYCLES, 8, clk cycles the oscillator runs before counting starts (≥SYNC_STAGES+1)
SYNC_STAGES, 2, flops in the ro_out synchronizer (≥2)
CNT_WIDTH, 16, width of the edge counter and count_out

Ports:
clk  input  1  system clock; all state is on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  measurement request; sampled only in IDLE
ro_out  input  1  oscillator output, asynchronous to clk
ro_enable  output  1  oscillator enable
busy  output  1  high in any state other than IDLE
count_valid  output  1  result available
count_ready  input  1  consumer accepts result
count_out  output  CNT_WIDTH  rising-edge count for the last window
overflow  output  1  counter saturated during the last window

Behaviour:
- Reset (async assert, sync release): state=IDLE; ro_enable=0; busy=0; count_valid=0; count_out=0; overflow=0; synchronizer and edge-detect prev flop=0; window timer=0.
- Input path: ro_out passes through SYNC_STAGES flops to give s. prev is s delayed by one clk. A rising edge is s=1 and prev=0. Synchronizer and prev update every cycle in every state.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE: if start=1 at edge T, then from T+1 state=SETTLE, ro_enable=1, edge counter=0, overflow=0, timer=0. count_out keeps its old value until DONE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles. No edges are counted. It then goes to MEASURE with timer=0.
- MEASURE: lasts exactly GATE_CYCLES cycles. Each cycle in MEASURE with a rising edge increments the counter by 1.
  - Saturation: at all-ones the counter holds and overflow sets and stays set.
  - When the timer reaches GATE_CYCLES-1, the next state is DONE. The edge in that final cycle is still counted.
- DONE:
  - Entry: count_out and overflow load the final values; count_valid=1; ro_enable=0 on the same edge.
  - Holding: count_out and overflow stay stable while count_valid=1.
  - Exit: when count_valid and count_ready are both 1 at an edge, count_valid=0 and state=IDLE on that edge.
- ro_enable=1 exactly in SETTLE and MEASURE.
- Latency: from the start edge to count_valid=1 is 1+SETTLE_CYCLES+GATE_CYCLES cycles.
- start outside IDLE is ignored, with no queuing. start held high in IDLE re-triggers one cycle after each handshake completes.
- count_ready outside DONE is ignored.
- Reset mid-operation: immediately returns to reset values, including ro_enable=0 and a discarded count.
- Accuracy: the count is exact only when the oscillator frequency is below clk/2. Faster oscillators alias; detecting that is the system's job, not this block's.
- Counter arithmetic: unsigned CNT_WIDTH bits, saturating, no wrap.
- The timer width is sized to hold max(GATE_CYCLES, SETTLE_CYCLES).

Test Plan:
- Basic measurement: bench drives ro_out as a clk-synchronous square wave of period 10 clk (5 high/5 low), GATE_CYCLES=100, SETTLE_CYCLES=8, start pulse -> ro_enable=1 for exactly 108 cycles; count_valid rises 109 cycles after start; count_out=10, overflow=0.
- Handshake hold: same as basic, with count_ready held 0 for 20 cycles then pulsed -> count_out stays 10 and count_valid stays 1 throughout; one cycle after the ready edge count_valid=0, busy=0; start pulses during busy produce no second measurement.
- Saturation: CNT_WIDTH=4, ro_out period 4, GATE_CYCLES=100 (25 edges) -> count_out=15, overflow=1; the next run at period 10 gives count_out=10, overflow=0.
- Reset mid-measure: assert rst 50 cycles into MEASURE -> ro_enable, busy, count_valid, count_out and overflow are all 0 immediately without waiting for clk; after release, a new start gives the normal result.
- Idle oscillator: ro_out tied 0 -> count_out=0, overflow=0; ro_out tied 1 from before start -> count_out=0, because no edge occurs after SETTLE.
- Back-to-back: start held at 1 and count_ready held at 1 -> consecutive results each 10, one IDLE cycle between DONE and the next SETTLE.
